// File: rtl/sync_wlif_synapse.sv
// -----------------------------------------------------------------------------
// sync_wlif_synapse
//
// One synapse of the SNN fabric.
// - An asynchronous spike is captured on the rising edge of i_event.
// - The spike is synchronised into the i_clk domain.
// - The programmable weight is then added into a fixed-point leaky
//   accumulator, which decays on every clock.
//
// The accumulator is p_width integer bits over p_resbit fractional bits.
//
// Ports:
//   i_clk     single clock; all clocked state updates on its rising edge
//   i_rst     asynchronous, active-high reset
//   i_event   asynchronous spike input; the rising edge is significant
//   i_weight  unsigned synaptic weight, sampled when a spike is accepted
//   o_sync    synchronised spike flag, high from capture until cleared
//   o_do      unsigned accumulator value (synaptic current)
//
// Sub-blocks:
//   sync_wlif_synapse_sync  edge capture plus two-flop synchroniser
//   sync_wlif_synapse_wlif  weighted leaky integrator
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sync_wlif_synapse_sync
//
// Captures an i_event rising edge in a sticky flag, then passes the flag
// through two i_clk flops.
//
// Ports:
//   i_clk, i_rst  clock and asynchronous reset
//   i_event       asynchronous spike
//   i_clr         one-cycle clear from the integrator
//   o_sync        output of the second synchroniser flop
// -----------------------------------------------------------------------------
module sync_wlif_synapse_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_event,
   input  logic i_clr,
   output logic o_sync
);

   logic r_flag;
   logic r_sync1;
   logic r_sync2;
   logic w_flag_clr;

   // The flag is clocked by the spike itself, so pulses of any width are seen.
   // i_clr is a registered, glitch-free signal. Using it as a level clear
   // holds the flag low for the whole clear cycle. An edge inside that cycle
   // is therefore dropped. Edges arriving while the flag is already set are
   // merged into the pending spike.
   assign w_flag_clr = i_rst | i_clr;

   always_ff @(posedge i_event or posedge w_flag_clr) begin
      if (w_flag_clr) begin
         r_flag <= 1'b0;
      end else begin
         r_flag <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else if (i_clr) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= r_flag;
         r_sync2 <= r_sync1;
      end
   end

   assign o_sync = r_sync2;

endmodule

// -----------------------------------------------------------------------------
// sync_wlif_synapse_wlif
//
// Weighted leaky integrator.
// - A rising edge of i_sync (seen against its registered copy) accepts a
//   spike:
//     - the accumulator takes a saturating add of the weight,
//     - no leak is applied in that cycle,
//     - o_clr pulses for the following cycle.
// - On every other cycle the accumulator decays:
//     - it loses acc >> p_leak,
//     - or 1 when that shift is zero, so the value always reaches 0.
//
// Ports:
//   i_clk, i_rst  clock and asynchronous reset
//   i_sync        synchronised spike flag
//   i_weight      unsigned weight, integer part of the accumulator
//   o_clr         one-cycle clear back to the synchroniser
//   o_do          registered accumulator value
// -----------------------------------------------------------------------------
module sync_wlif_synapse_wlif #(
   parameter int p_width  = 8,
   parameter int p_resbit = 8,
   parameter int p_leak   = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_sync,
   input  logic [p_width-1:0]          i_weight,
   output logic                        o_clr,
   output logic [p_width+p_resbit-1:0] o_do
);

   localparam int c_w = p_width + p_resbit;
   localparam logic [c_w-1:0] c_max = {c_w{1'b1}};

   logic           r_sync_d;
   logic           r_clr;
   logic [c_w-1:0] r_acc;

   logic           w_accept;
   logic [c_w-1:0] w_addend;
   logic [c_w:0]   w_sum;
   logic [c_w-1:0] w_leak;
   logic [c_w-1:0] w_dec;
   logic [c_w-1:0] w_acc_next;

   assign w_accept = i_sync & ~r_sync_d;
   assign w_addend = c_w'(i_weight) << p_resbit;

   // The extra top bit of the sum is the saturation indicator.
   assign w_sum  = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_leak = r_acc >> p_leak;

   // Small values shift to zero, so they step down by one LSB instead.
   assign w_dec = (w_leak != '0) ? w_leak : c_w'(1);

   always_comb begin
      w_acc_next = r_acc;
      if (w_accept) begin
         w_acc_next = w_sum[c_w] ? c_max : w_sum[c_w-1:0];
      end else if (r_acc != '0) begin
         w_acc_next = r_acc - w_dec;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync_d <= 1'b0;
         r_clr    <= 1'b0;
         r_acc    <= '0;
      end else begin
         r_sync_d <= i_sync;
         r_clr    <= w_accept;
         r_acc    <= w_acc_next;
      end
   end

   assign o_clr = r_clr;
   assign o_do  = r_acc;

endmodule

// -----------------------------------------------------------------------------
// sync_wlif_synapse: top level, wiring the synchroniser to the integrator.
// -----------------------------------------------------------------------------
module sync_wlif_synapse #(
   parameter int p_width  = 8,
   parameter int p_resbit = 8,
   parameter int p_leak   = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_event,
   input  logic [p_width-1:0]          i_weight,
   output logic                        o_sync,
   output logic [p_width+p_resbit-1:0] o_do
);

   logic w_sync;
   logic w_clr;

   sync_wlif_synapse_sync u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_event (i_event),
      .i_clr   (w_clr),
      .o_sync  (w_sync)
   );

   sync_wlif_synapse_wlif #(
      .p_width  (p_width),
      .p_resbit (p_resbit),
      .p_leak   (p_leak)
   ) u_wlif (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sync   (w_sync),
      .i_weight (i_weight),
      .o_clr    (w_clr),
      .o_do     (o_do)
   );

   assign o_sync = w_sync;

endmodule

// File: tb/tb_sync_wlif_synapse.sv
// -----------------------------------------------------------------------------
// tb_sync_wlif_synapse
//
// Checks sync_wlif_synapse with p_width=8, p_resbit=8, p_leak=4 against:
// - a spike-level reference model, compared on every falling clock edge;
// - hand-computed values at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_sync_wlif_synapse;

   logic        clk    = 1'b0;
   logic        rst    = 1'b0;
   logic        ev     = 1'b0;
   logic [7:0]  weight = 8'h00;
   logic        o_sync;
   logic [15:0] o_do;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model.
   // - edge_cnt counts rising clock edges.
   // - acc_edge is the edge number at which the pending spike is accepted.
   // - m_acc is the expected synaptic current.
   int          edge_cnt = 0;
   int          acc_edge = -100;
   int unsigned m_acc    = 0;

   sync_wlif_synapse #(
      .p_width  (8),
      .p_resbit (8),
      .p_leak   (4)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_event  (ev),
      .i_weight (weight),
      .o_sync   (o_sync),
      .o_do     (o_do)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: accumulator update on each clock edge.
   initial forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      if (rst) begin
         m_acc = 0;
      end else if (edge_cnt == acc_edge) begin
         m_acc = m_acc + int'(weight) * 256;
         if (m_acc > 65535) m_acc = 65535;
      end else if (m_acc != 0) begin
         if (m_acc / 16 != 0) m_acc = m_acc - m_acc / 16;
         else                 m_acc = m_acc - 1;
      end
   end

   // Model: spike arrival.
   // A spike is accepted three edges after it arrives.
   // - Arriving before a pending accept, it merges into that spike.
   // - Arriving in the cycle just after an accept, it is lost.
   initial forever begin
      @(posedge ev);
      if (!rst && edge_cnt > acc_edge) acc_edge = edge_cnt + 3;
   end

   // Model: asynchronous reset.
   initial forever begin
      @(posedge rst);
      m_acc    = 0;
      acc_edge = -100;
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      check("model_o_do", {16'h0, o_do}, rst ? 32'h0 : m_acc);
      check("model_o_sync", {31'h0, o_sync},
            {31'h0, (!rst && (edge_cnt == acc_edge - 1 || edge_cnt == acc_edge))});
   end

   // Drive a 2 ns spike shortly after the next rising clock edge.
   task automatic pulse();
      @(posedge clk);
      #3 ev = 1'b1;
      #2 ev = 1'b0;
   endtask

   task automatic step_check(input string name, input logic [15:0] exp_do);
      @(posedge clk);
      #2;
      check(name, {16'h0, o_do}, {16'h0, exp_do});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int v;

      // Reset with event toggling.
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #2 ev = 1'b1;
         #3 ev = 1'b0;
      end
      #1;
      check("rst_o_do", {16'h0, o_do}, 32'h0);
      check("rst_o_sync", {31'h0, o_sync}, 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_check("post_rst_o_do", 16'h0000);
         check("post_rst_o_sync", {31'h0, o_sync}, 32'h0);
      end

      // Single spike, weight 0x10.
      weight = 8'h10;
      pulse();
      @(posedge clk);
      @(posedge clk);
      #2;
      check("spike_sync_e1", {31'h0, o_sync}, 32'h1);
      step_check("spike_e2", 16'h1000);
      check("spike_sync_e2", {31'h0, o_sync}, 32'h1);
      step_check("spike_e3", 16'h0F00);
      check("spike_sync_e3", {31'h0, o_sync}, 32'h0);
      step_check("spike_e4", 16'h0E10);

      // Small-value decay: one LSB per cycle once below 16, then held at 0.
      found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         @(posedge clk);
         #2;
         if (o_do < 16) found = 1;
      end
      check("reach_small", found, 32'h1);
      if (found == 1) begin
         v = int'(o_do);
         for (int k = v - 1; k >= 0; k--) step_check("decay_lsb", 16'(k));
      end
      for (int i = 0; i < 3; i++) step_check("hold_zero", 16'h0000);

      // Saturation: two spikes, accepts 4 cycles apart.
      weight = 8'hFF;
      pulse();
      repeat (3) @(posedge clk);
      #2;
      check("sat_first", {16'h0, o_do}, 32'hFF00);
      pulse();
      repeat (3) @(posedge clk);
      #2;
      check("sat_second", {16'h0, o_do}, 32'hFFFF);
      step_check("sat_leak", 16'hF000);
      repeat (250) @(posedge clk);
      #2;
      check("sat_decayed", {16'h0, o_do}, 32'h0);

      // Merge two edges one cycle apart, then lose an edge during the clear.
      weight = 8'h20;
      pulse();
      pulse();
      repeat (2) @(posedge clk);
      #2;
      check("merge_accept", {16'h0, o_do}, 32'h2000);
      #1 ev = 1'b1;
      #2 ev = 1'b0;
      step_check("merge_e3", 16'h1E00);
      step_check("lost_e4", 16'h1C20);
      step_check("lost_e5", 16'h1A5E);
      check("lost_sync", {31'h0, o_sync}, 32'h0);
      repeat (200) @(posedge clk);
      #2;
      check("merge_decayed", {16'h0, o_do}, 32'h0);

      // Asynchronous reset mid-decay.
      weight = 8'h08;
      pulse();
      repeat (3) @(posedge clk);
      #2;
      check("pre_arst", {16'h0, o_do}, 32'h0800);
      #1 rst = 1'b1;
      #1;
      check("arst_o_do", {16'h0, o_do}, 32'h0);
      check("arst_o_sync", {31'h0, o_sync}, 32'h0);
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) step_check("post_arst", 16'h0000);

      // A pending spike is discarded by reset.
      pulse();
      @(posedge clk);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step_check("discard_o_do", 16'h0000);
         check("discard_o_sync", {31'h0, o_sync}, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
